// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one fifo_mem write port between N_REQ producers,
// with bursts of up to MAX_BURST beats and per-cycle fifo_full back-pressure.
module fifo_wr_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [N_REQ-1:0]                       req,
  input  logic [N_REQ*DATA_W-1:0]                req_data,
  output logic [N_REQ-1:0]                       gnt,
  input  logic                                   fifo_full,
  output logic                                   fifo_wr,
  output logic [DATA_W-1:0]                      fifo_din,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] owner,
  output logic                                   busy
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_REQ-1:0]  gnt_vec;
  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  scan_idx;
  logic [DATA_W-1:0] din_c;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] k);
    if (32'(k) == N_REQ - 1) return '0;
    return k + IDX_W'(1);
  endfunction

  // Scan from the far end so the requester closest to rr_q wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      scan_idx = IDX_W'((32'(rr_q) + 32'(i)) % N_REQ);
      if (req[scan_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gnt_vec = '0;
    case (state_q)
      IDLE: begin
        if (!fifo_full && pick_valid) begin
          gnt_vec[pick_idx] = 1'b1;
          owner_d           = pick_idx;
          cnt_d             = CNT_W'(1);
          if (MAX_BURST == 1) rr_d = next_idx(pick_idx);
          else                state_d = BURST;
        end
      end
      BURST: begin
        if (req[owner_q]) begin
          if (!fifo_full) begin
            gnt_vec[owner_q] = 1'b1;
            cnt_d            = cnt_q + CNT_W'(1);
            if (cnt_q + CNT_W'(1) == CNT_W'(MAX_BURST)) begin
              state_d = IDLE;
              rr_d    = next_idx(owner_q);
            end
          end
        end else begin
          // Owner dropped req: one dead cycle, then re-arbitrate past it.
          state_d = IDLE;
          rr_d    = next_idx(owner_q);
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) gnt_vec = '0;
  end

  always_comb begin
    din_c = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (gnt_vec[k]) din_c = req_data[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt      = gnt_vec;
  assign fifo_wr  = |gnt_vec;
  assign fifo_din = din_c;
  assign owner    = owner_q;
  assign busy     = (state_q == BURST) && !rst;

endmodule
